alu_const_scheduler: RTL

// - Sequences the ALU constant-operand selector: turns a constant request (RST vector, NMI, bit mask, DAA fix, ...) into
//   the one-hot select lines of the constant input mux and holds them until the ALU takes the operand.
// - Sits between the microcode decoder and the constant mux. DAA can be issued as two operand beats. A watchdog aborts stalled beats.

---
 rtl/alu_const_pkg.sv | 49 ++++
 rtl/alu_const_decode.sv | 73 +++++++
 rtl/alu_const_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_const_pkg.sv
// Shared definitions for the ALU constant-operand scheduler: select bit
// indices, request kind codes, FSM encoding and a one-hot helper.
package alu_const_pkg;

    localparam int SEL_W = 18;

    localparam int SEL_01H  = 0;
    localparam int SEL_FF00 = 1;
    localparam int SEL_01L  = 2;
    localparam int SEL_08   = 3;
    localparam int SEL_10   = 4;
    localparam int SEL_18   = 5;
    localparam int SEL_20   = 6;
    localparam int SEL_28   = 7;
    localparam int SEL_30   = 8;
    localparam int SEL_38   = 9;
    localparam int SEL_66   = 10;
    localparam int SEL_AA   = 11;
    localparam int SEL_06   = 12;
    localparam int SEL_60   = 13;
    localparam int SEL_02   = 14;
    localparam int SEL_04   = 15;
    localparam int SEL_40   = 16;
    localparam int SEL_80   = 17;

    typedef enum logic [2:0] {
        KIND_RST     = 3'd0,
        KIND_NMI     = 3'd1,
        KIND_INCDEC  = 3'd2,
        KIND_BITMASK = 3'd3,
        KIND_DAA     = 3'd4,
        KIND_SEXT    = 3'd5,
        KIND_PATTERN = 3'd6,
        KIND_HIGH1   = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2
    } state_e;

    function automatic logic [SEL_W-1:0] sel_onehot(input int idx);
        logic [SEL_W-1:0] v;
        v = {{(SEL_W-1){1'b0}}, 1'b1};
        return v << idx;
    endfunction

endpackage

// File: rtl/alu_const_decode.sv
// Combinational decode of a constant request into the first-beat select
// vector and a flag marking a pending second DAA beat.
module alu_const_decode
    import alu_const_pkg::*;
#(
    parameter int SPLIT_DAA = 1
) (
    input  logic [2:0]       kind,
    input  logic [2:0]       arg,
    input  logic             daa_lo,
    input  logic             daa_hi,
    output logic [SEL_W-1:0] sel_first,
    output logic             second_beat
);

    // Request kind/argument to one-hot constant select
    always_comb begin
        sel_first   = '0;
        second_beat = 1'b0;
        case (kind)
            KIND_RST: begin
                case (arg)
                    3'd0:    sel_first = '0;
                    3'd1:    sel_first = sel_onehot(SEL_08);
                    3'd2:    sel_first = sel_onehot(SEL_10);
                    3'd3:    sel_first = sel_onehot(SEL_18);
                    3'd4:    sel_first = sel_onehot(SEL_20);
                    3'd5:    sel_first = sel_onehot(SEL_28);
                    3'd6:    sel_first = sel_onehot(SEL_30);
                    3'd7:    sel_first = sel_onehot(SEL_38);
                    default: sel_first = '0;
                endcase
            end
            KIND_NMI:     sel_first = sel_onehot(SEL_66);
            KIND_INCDEC:  sel_first = sel_onehot(SEL_01L);
            KIND_BITMASK: begin
                case (arg)
                    3'd0:    sel_first = sel_onehot(SEL_01L);
                    3'd1:    sel_first = sel_onehot(SEL_02);
                    3'd2:    sel_first = sel_onehot(SEL_04);
                    3'd3:    sel_first = sel_onehot(SEL_08);
                    3'd4:    sel_first = sel_onehot(SEL_10);
                    3'd5:    sel_first = sel_onehot(SEL_20);
                    3'd6:    sel_first = sel_onehot(SEL_40);
                    3'd7:    sel_first = sel_onehot(SEL_80);
                    default: sel_first = '0;
                endcase
            end
            KIND_DAA: begin
                // Both fixes: either one combined 0x66 or 0x06 now and 0x60 next beat
                if (daa_lo && daa_hi) begin
                    if (SPLIT_DAA != 0) begin
                        sel_first   = sel_onehot(SEL_06);
                        second_beat = 1'b1;
                    end else begin
                        sel_first = sel_onehot(SEL_66);
                    end
                end else if (daa_lo) begin
                    sel_first = sel_onehot(SEL_06);
                end else if (daa_hi) begin
                    sel_first = sel_onehot(SEL_60);
                end else begin
                    sel_first = '0;
                end
            end
            KIND_SEXT:    sel_first = sel_onehot(SEL_FF00);
            KIND_PATTERN: sel_first = sel_onehot(SEL_AA);
            KIND_HIGH1:   sel_first = sel_onehot(SEL_01H);
            default:      sel_first = '0;
        endcase
    end

endmodule

// File: rtl/alu_const_scheduler.sv
// Constant-operand scheduler: accepts a request, presents the registered
// one-hot select for one or two beats, with watchdog abort and flush.
module alu_const_scheduler
    import alu_const_pkg::*;
#(
    parameter int SPLIT_DAA      = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Req_Valid,
    output logic             Req_Ready,
    input  logic [2:0]       Req_Kind,
    input  logic [2:0]       Req_Arg,
    input  logic             Daa_Lo_Adj,
    input  logic             Daa_Hi_Adj,
    input  logic             Flush,
    input  logic             Alu_Accept,
    output logic [SEL_W-1:0] Sel,
    output logic             Beat,
    output logic             Done,
    output logic             Err
);

    localparam int           CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_r, state_nxt_s;
    logic [SEL_W-1:0] sel_r, sel_nxt_s, dec_sel_s;
    logic             beat_r, beat_nxt_s;
    logic             done_r, done_nxt_s;
    logic             err_r, err_nxt_s;
    logic             ready_r;
    logic             split_r, split_nxt_s, dec_second_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;

    alu_const_decode #(.SPLIT_DAA(SPLIT_DAA)) u_decode (
        .kind        (Req_Kind),
        .arg         (Req_Arg),
        .daa_lo      (Daa_Lo_Adj),
        .daa_hi      (Daa_Hi_Adj),
        .sel_first   (dec_sel_s),
        .second_beat (dec_second_s)
    );

    // Next-state, select and watchdog logic; flush overrides everything
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        beat_nxt_s  = beat_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        cnt_nxt_s   = cnt_r;
        split_nxt_s = split_r;
        if (Flush) begin
            state_nxt_s = ST_IDLE;
            sel_nxt_s   = '0;
            beat_nxt_s  = 1'b0;
            cnt_nxt_s   = '0;
            split_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Req_Valid) begin
                        state_nxt_s = ST_BEAT1;
                        sel_nxt_s   = dec_sel_s;
                        beat_nxt_s  = 1'b0;
                        cnt_nxt_s   = '0;
                        split_nxt_s = dec_second_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BEAT1, ST_BEAT2: begin
                    // Accept wins over a watchdog expiry in the same cycle
                    if (Alu_Accept) begin
                        if ((state_r == ST_BEAT1) && split_r) begin
                            state_nxt_s = ST_BEAT2;
                            sel_nxt_s   = sel_onehot(SEL_60);
                            beat_nxt_s  = 1'b1;
                            cnt_nxt_s   = '0;
                            split_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            sel_nxt_s   = '0;
                            beat_nxt_s  = 1'b0;
                            cnt_nxt_s   = '0;
                            split_nxt_s = 1'b0;
                            done_nxt_s  = 1'b1;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_IDLE;
                        sel_nxt_s   = '0;
                        beat_nxt_s  = 1'b0;
                        cnt_nxt_s   = '0;
                        split_nxt_s = 1'b0;
                        err_nxt_s   = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    sel_nxt_s   = '0;
                    beat_nxt_s  = 1'b0;
                    cnt_nxt_s   = '0;
                    split_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            beat_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
            split_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            beat_r  <= beat_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            split_r <= split_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign Sel       = sel_r;
    assign Beat      = beat_r;
    assign Done      = done_r;
    assign Err       = err_r;
    assign Req_Ready = ready_r;

endmodule
